// File: rtl/morse_key_decoder.sv
// Hand-key Morse receiver: synchronises and debounces KEY, times marks and gaps in
// Morse units, decodes each element string to ASCII and flags the S-O-S sequence.
module morse_key_decoder #(
    parameter int unsigned UNIT_CYCLES     = 2097152,
    parameter int unsigned DEBOUNCE_CYCLES = 16000,
    parameter int unsigned MAX_ELEMS       = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY,
    output logic       KEY_LEVEL,
    output logic [7:0] CHAR_DATA,
    output logic       CHAR_VALID,
    output logic       SOS_DET
);

    localparam int unsigned CNT_W = $clog2(5 * UNIT_CYCLES + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LEN_W = $clog2(MAX_ELEMS + 1);

    localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_ELEMS);
    localparam logic [7:0]       CH_SPACE = 8'h20;
    localparam logic [7:0]       CH_UNK   = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        WORD
    } state_t;

    logic                 key_meta_q;
    logic                 key_sync_q;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                 key_level_q, key_level_d;
    logic                 key_prev_q;
    logic                 rise, fall;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 clr_cnt;

    state_t               state_q, state_d;
    logic [MAX_ELEMS-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 err_q, err_d;
    logic                 emit_char, emit_space;

    logic [7:0]           decoded;
    logic [7:0]           char_data_q, char_data_d;
    logic                 char_valid_q, char_valid_d;
    logic                 sos_q, sos_d;
    logic [7:0]           hist_old_q, hist_old_d;
    logic [7:0]           hist_new_q, hist_new_d;

    // Keyed by (length, elements) with the first element in bit 0, dash = 1.
    function automatic logic [7:0] decode(input logic [LEN_W-1:0] len,
                                          input logic [MAX_ELEMS-1:0] code);
        logic [11:0] key;
        key = {4'(len), 8'(code)};
        case (key)
            {4'd1, 8'd0}:  decode = "E";
            {4'd1, 8'd1}:  decode = "T";
            {4'd2, 8'd0}:  decode = "I";
            {4'd2, 8'd1}:  decode = "N";
            {4'd2, 8'd2}:  decode = "A";
            {4'd2, 8'd3}:  decode = "M";
            {4'd3, 8'd0}:  decode = "S";
            {4'd3, 8'd1}:  decode = "D";
            {4'd3, 8'd2}:  decode = "R";
            {4'd3, 8'd3}:  decode = "G";
            {4'd3, 8'd4}:  decode = "U";
            {4'd3, 8'd5}:  decode = "K";
            {4'd3, 8'd6}:  decode = "W";
            {4'd3, 8'd7}:  decode = "O";
            {4'd4, 8'd0}:  decode = "H";
            {4'd4, 8'd1}:  decode = "B";
            {4'd4, 8'd2}:  decode = "L";
            {4'd4, 8'd3}:  decode = "Z";
            {4'd4, 8'd4}:  decode = "F";
            {4'd4, 8'd5}:  decode = "C";
            {4'd4, 8'd6}:  decode = "P";
            {4'd4, 8'd8}:  decode = "V";
            {4'd4, 8'd9}:  decode = "X";
            {4'd4, 8'd11}: decode = "Q";
            {4'd4, 8'd13}: decode = "Y";
            {4'd4, 8'd14}: decode = "J";
            {4'd5, 8'd0}:  decode = "5";
            {4'd5, 8'd1}:  decode = "6";
            {4'd5, 8'd3}:  decode = "7";
            {4'd5, 8'd7}:  decode = "8";
            {4'd5, 8'd15}: decode = "9";
            {4'd5, 8'd16}: decode = "4";
            {4'd5, 8'd24}: decode = "3";
            {4'd5, 8'd28}: decode = "2";
            {4'd5, 8'd30}: decode = "1";
            {4'd5, 8'd31}: decode = "0";
            default:       decode = CH_UNK;
        endcase
    endfunction

    // A new level must persist DEBOUNCE_CYCLES consecutive cycles to be accepted.
    always_comb begin
        db_cnt_d    = '0;
        key_level_d = key_level_q;
        if (key_sync_q != key_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_level_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = key_level_q & ~key_prev_q;
    assign fall = ~key_level_q & key_prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall || clr_cnt) begin
            cnt_d = '0;
        end else if (cnt_q != WORD_TH) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        len_d      = len_q;
        err_d      = err_q;
        clr_cnt    = 1'b0;
        emit_char  = 1'b0;
        emit_space = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = MARK;
            end
            MARK: begin
                if (fall) begin
                    if (len_q == LEN_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        buf_d[len_q] = (cnt_q >= GAP_TH);
                        len_d        = len_q + 1'b1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                // A rise on the threshold cycle keeps the character open.
                if (rise) begin
                    state_d = MARK;
                end else if (cnt_q == GAP_TH) begin
                    emit_char = 1'b1;
                    buf_d     = '0;
                    len_d     = '0;
                    err_d     = 1'b0;
                    clr_cnt   = 1'b1;
                    state_d   = WORD;
                end
            end
            WORD: begin
                if (rise) begin
                    state_d = MARK;
                end else if (cnt_q == WORD_TH) begin
                    emit_space = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        decoded      = err_q ? CH_UNK : decode(len_q, buf_q);
        char_valid_d = emit_char | emit_space;
        char_data_d  = char_data_q;
        sos_d        = 1'b0;
        hist_old_d   = hist_old_q;
        hist_new_d   = hist_new_q;
        if (emit_space) begin
            char_data_d = CH_SPACE;
            hist_old_d  = '0;
            hist_new_d  = '0;
        end else if (emit_char) begin
            char_data_d = decoded;
            sos_d       = (decoded == "S") && (hist_old_q == "S") && (hist_new_q == "O");
            hist_old_d  = hist_new_q;
            hist_new_d  = decoded;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_meta_q   <= 1'b0;
            key_sync_q   <= 1'b0;
            db_cnt_q     <= '0;
            key_level_q  <= 1'b0;
            key_prev_q   <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
            buf_q        <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            char_data_q  <= '0;
            char_valid_q <= 1'b0;
            sos_q        <= 1'b0;
            hist_old_q   <= '0;
            hist_new_q   <= '0;
        end else begin
            key_meta_q   <= KEY;
            key_sync_q   <= key_meta_q;
            db_cnt_q     <= db_cnt_d;
            key_level_q  <= key_level_d;
            key_prev_q   <= key_level_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            err_q        <= err_d;
            char_data_q  <= char_data_d;
            char_valid_q <= char_valid_d;
            sos_q        <= sos_d;
            hist_old_q   <= hist_old_d;
            hist_new_q   <= hist_new_d;
        end
    end

    assign KEY_LEVEL  = key_level_q;
    assign CHAR_DATA  = char_data_q;
    assign CHAR_VALID = char_valid_q;
    assign SOS_DET    = sos_q;

endmodule
